// File: rtl/frec_period_meter_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the slow-clock period meter.
package frec_period_meter_pkg;

  localparam int unsigned CNT_W_DEF  = 20;
  localparam int unsigned SYS_CLK_HZ = 100_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/frec_period_meter_sync_edge_detect.sv
`timescale 1ns/1ps
// Synchronizes an asynchronous level and emits registered rise/fall strobes.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Synchronizer chain, edge-detect flop and strobe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      level  <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~level;
      fall   <= ~sync_q[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/frec_period_meter.sv
`timescale 1ns/1ps
// Measures period and high time of a slow asynchronous clock in clk cycles.
module frec_period_meter
  import frec_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TOL         = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [CNT_W-1:0] period_d, high_d;
  logic             valid_d, locked_d, timeout_d;
  logic             have_prev, have_prev_d;
  logic [CNT_W:0]   new_ext, old_ext, abs_diff;
  logic             within_tol;
  logic             rise, fall, sync_level_unused;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (clk_in),
    .level    (sync_level_unused),
    .rise     (rise),
    .fall     (fall)
  );

  // Saturating count+1 and lock distance against the held period.
  always_comb begin
    cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    new_ext    = {1'b0, cnt_inc};
    old_ext    = {1'b0, period};
    abs_diff   = (new_ext >= old_ext) ? new_ext - old_ext : old_ext - new_ext;
    within_tol = (abs_diff <= (CNT_W+1)'(TOL));
  end

  // Next-state, counter and result update.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    period_d    = period;
    high_d      = high_time;
    valid_d     = 1'b0;
    locked_d    = locked;
    timeout_d   = timeout;
    have_prev_d = have_prev;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d     = ARM;
          have_prev_d = 1'b0;
        end
      end
      ARM: begin
        cnt_d = '0;
        if (!enable)   state_d = IDLE;
        else if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (!enable) begin
          state_d  = IDLE;
          cnt_d    = '0;
          locked_d = 1'b0;
        end else begin
          if (fall) high_d = cnt_inc;
          if (rise) begin
            period_d    = cnt_inc;
            cnt_d       = '0;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            locked_d    = have_prev & within_tol;
            have_prev_d = 1'b1;
          end else if (cnt == CNT_MAX) begin
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            state_d     = ARM;
            cnt_d       = '0;
            have_prev_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      have_prev    <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      period       <= period_d;
      high_time    <= high_d;
      period_valid <= valid_d;
      locked       <= locked_d;
      timeout      <= timeout_d;
      have_prev    <= have_prev_d;
    end
  end

endmodule

// File: tb/tb_frec_period_meter.sv
`timescale 1ns/1ps
// Self-checking bench for frec_period_meter (reduced counter width).
module tb_frec_period_meter;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned MAXC  = (1 << CNT_W) - 1;
  localparam int unsigned TOL   = 2;

  logic             clk = 1'b0;
  logic             reset, clk_in, enable;
  logic [CNT_W-1:0] period, high_time;
  logic             period_valid, locked, timeout;

  frec_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TOL(TOL)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_in       (clk_in),
    .enable       (enable),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned per; int unsigned hi; bit lck; bit tmo; } obs_t;
  typedef struct { int unsigned hi; int unsigned lo; obs_t exp; } vec_t;

  obs_t        got_q[$];
  obs_t        exp_q[$];
  obs_t        mon_o, pend_obs;
  int          vectors = 0, miscompares = 0;
  int          vcount = 0, dbl = 0;
  bit          prev_v = 1'b0;
  bit          pend = 1'b0, have_prev = 1'b0;
  int unsigned prev_per = 0, held_per = 0;

  // Capture every period_valid pulse and flag pulses wider than one cycle.
  always @(negedge clk) begin
    if (period_valid) begin
      mon_o.per = 32'(period);
      mon_o.hi  = 32'(high_time);
      mon_o.lck = locked;
      mon_o.tmo = timeout;
      got_q.push_back(mon_o);
      vcount++;
      if (prev_v) dbl++;
    end
    prev_v = period_valid;
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_near(input string nm, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act + 1 < exp || act > exp + 1) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d+-1", nm, act, exp);
    end
  endtask

  function automatic int unsigned absdiff(input int unsigned a, input int unsigned b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Reference: measured period saturates at the limit; lock needs a prior measurement.
  task automatic model_next(input int unsigned hi, input int unsigned lo, output obs_t e);
    int unsigned per;
    per   = (hi + lo > MAXC) ? MAXC : hi + lo;
    e.per = per;
    e.hi  = hi;
    e.lck = have_prev && (absdiff(per, prev_per) <= TOL);
    e.tmo = 1'b0;
    have_prev = 1'b1;
    prev_per  = per;
    held_per  = per;
  endtask

  task automatic rearm();
    pend      = 1'b0;
    have_prev = 1'b0;
  endtask

  // Drive one clk_in period; the rise completes the previous measured period.
  task automatic run_period(input int unsigned hi, input int unsigned lo, input obs_t e);
    if (pend) exp_q.push_back(pend_obs);
    pend     = 1'b1;
    pend_obs = e;
    clk_in   = 1'b1;
    repeat (hi) @(negedge clk);
    clk_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic drain();
    obs_t g, e;
    repeat (8) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_valid: got none expected period %0d", e.per);
      end else begin
        g = got_q.pop_front();
        chk("period", g.per, e.per);
        chk("high_time", g.hi, e.hi);
        chk("locked", 32'(g.lck), 32'(e.lck));
        chk("timeout_at_valid", 32'(g.tmo), 32'(e.tmo));
      end
    end
    chk("extra_valids", 32'(got_q.size()), 0);
    got_q.delete();
  endtask

  vec_t tbl[13];

  initial begin
    obs_t e, g;
    int unsigned per, hi, v0;

    tbl[0]  = '{50,  50,  '{100,  50,   1'b0, 1'b0}};
    tbl[1]  = '{50,  50,  '{100,  50,   1'b1, 1'b0}};
    tbl[2]  = '{50,  52,  '{102,  50,   1'b1, 1'b0}};
    tbl[3]  = '{51,  49,  '{100,  51,   1'b1, 1'b0}};
    tbl[4]  = '{50,  52,  '{102,  50,   1'b1, 1'b0}};
    tbl[5]  = '{55,  50,  '{105,  55,   1'b0, 1'b0}};
    tbl[6]  = '{50,  50,  '{100,  50,   1'b0, 1'b0}};
    tbl[7]  = '{50,  50,  '{100,  50,   1'b1, 1'b0}};
    tbl[8]  = '{30,  71,  '{101,  30,   1'b1, 1'b0}};
    tbl[9]  = '{1,   3,   '{4,    1,    1'b0, 1'b0}};
    tbl[10] = '{1000, 24, '{1023, 1000, 1'b0, 1'b0}};
    tbl[11] = '{600, 423, '{1023, 600,  1'b1, 1'b0}};
    tbl[12] = '{2,   2,   '{4,    2,    1'b0, 1'b0}};

    // Reset, then idle with enable low.
    reset = 1'b0; clk_in = 1'b0; enable = 1'b0;
    #100 reset = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst_period", 32'(period), 0);
    chk("rst_high_time", 32'(high_time), 0);
    chk("rst_valid", 32'(period_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("idle_no_valid", 32'(vcount), 0);
    enable = 1'b1;
    repeat (50) @(negedge clk);
    chk("armed_no_valid", 32'(vcount), 0);

    // Table-driven periods including lock tolerance and saturation at the limit.
    foreach (tbl[i]) begin
      model_next(tbl[i].hi, tbl[i].lo, e);
      run_period(tbl[i].hi, tbl[i].lo, tbl[i].exp);
    end

    // Randomized periods near a nominal value, with occasional jumps.
    for (int i = 0; i < 24; i++) begin
      per = ((i % 8) == 7) ? 150 : 300;
      per = per + $urandom_range(0, 3);
      hi  = $urandom_range(1, per - 1);
      model_next(hi, per - hi, e);
      run_period(hi, per - hi, e);
    end

    // Timeout: one rise then clk_in held low past the counter limit.
    if (pend) exp_q.push_back(pend_obs);
    pend   = 1'b0;
    clk_in = 1'b1;
    repeat (20) @(negedge clk);
    clk_in = 1'b0;
    repeat (MAXC + 4 - 20) @(negedge clk);
    chk("timeout_early", 32'(timeout), 0);
    @(negedge clk);
    chk("timeout_set", 32'(timeout), 1);
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_period_held", 32'(period), held_per);
    rearm();
    drain();

    // Restart after timeout: first new valid needs two rises.
    model_next(50, 50, e);
    run_period(50, 50, e);
    chk("timeout_sticky", 32'(timeout), 1);
    model_next(50, 50, e);
    run_period(50, 50, e);
    model_next(50, 50, e);
    run_period(50, 50, e);

    // Disable mid-period, rise while disabled, then re-enable.
    if (pend) exp_q.push_back(pend_obs);
    rearm();
    clk_in = 1'b1;
    repeat (30) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("dis_locked", 32'(locked), 0);
    chk("dis_period_held", 32'(period), held_per);
    v0 = 32'(vcount);
    clk_in = 1'b0;
    repeat (40) @(negedge clk);
    clk_in = 1'b1;
    repeat (20) @(negedge clk);
    clk_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("dis_no_valid", 32'(vcount) - v0, 0);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    drain();
    for (int i = 0; i < 3; i++) begin
      model_next(60, 40, e);
      run_period(60, 40, e);
    end

    // Short asynchronous reset pulse during the low phase.
    repeat (20) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst_period", 32'(period), 0);
    chk("arst_high_time", 32'(high_time), 0);
    chk("arst_valid", 32'(period_valid), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_timeout", 32'(timeout), 0);
    #1 reset = 1'b1;
    rearm();
    held_per = 0;
    drain();

    // Asynchronous-phase input: 40-cycle period, 20-cycle high.
    @(negedge clk);
    #3.3;
    for (int k = 0; k < 6; k++) begin
      clk_in = 1'b1;
      #200;
      clk_in = 1'b0;
      #200;
    end
    #200;
    chk("async_valid_count", 32'(got_q.size()), 5);
    for (int k = 0; k < 5 && got_q.size() > 0; k++) begin
      g = got_q.pop_front();
      chk_near("async_period", g.per, 40);
      chk_near("async_high_time", g.hi, 20);
      chk("async_locked", 32'(g.lck), (k == 0) ? 0 : 1);
    end
    got_q.delete();

    chk("valid_single_cycle", 32'(dbl), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
